// File: rtl/pcap_replay_pacer_pkg.sv
// Shared definitions for the pcap replay pacer: FSM state encoding, timestamp layout, delta clamp.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pcap_replay_pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_GAP  = 2'd2,
        ST_FWD  = 2'd3
    } pacer_state_t;

    localparam int unsigned USEC_PER_SEC = 1_000_000;

    // Timestamp portion of the pcap record header.
    typedef struct packed {
        logic [31:0] ts_sec;
        logic [31:0] ts_usec;
    } rec_hdr_ts_t;

    // Negative deltas mean the capture clock went backwards: release immediately.
    // Deltas beyond 32 bits saturate rather than wrap.
    function automatic logic [31:0] clamp_delta(input logic signed [63:0] d);
        if (d < 64'sd0) begin
            return 32'd0;
        end else if (d > 64'sh0000_0000_FFFF_FFFF) begin
            return 32'hFFFF_FFFF;
        end else begin
            return d[31:0];
        end
    endfunction

endpackage

// File: rtl/pcap_replay_pacer_usec_timer.sv
// Microsecond timer: prescaler 0..CYCLES_PER_US-1, each wrap bumps a saturating elapsed_us count.
// Latency: i_clr takes effect on the next edge; o_elapsed_us is the registered count.
// Backpressure: none; free-running except for the synchronous clear.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_clr synchronous clear,
//        o_elapsed_us microseconds since the last clear.
module pcap_replay_pacer_usec_timer #(
    parameter int unsigned CYCLES_PER_US = 250
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    output logic [31:0] o_elapsed_us
);

    localparam int unsigned PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_US - 1);

    logic [PW-1:0] r_presc;
    logic [31:0]   r_elapsed_us;
    logic          w_wrap;

    assign w_wrap       = (r_presc == PRESC_MAX);
    assign o_elapsed_us = r_elapsed_us;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc      <= '0;
            r_elapsed_us <= '0;
        end else if (i_clr) begin
            r_presc      <= '0;
            r_elapsed_us <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
            if (r_elapsed_us != 32'hFFFF_FFFF) begin
                r_elapsed_us <= r_elapsed_us + 32'd1;
            end
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

endmodule

// File: rtl/pcap_replay_pacer.sv
// Replays captured packets with their original inter-packet timing (start-to-start) or back-to-back.
// Latency: header -> first beat is 3 cycles minimum (IDLE, CALC, GAP); data path is combinational.
// Backpressure: M_TREADY passes straight to S_TREADY in FWD; headers stall (HDR_READY=0) outside IDLE.
// Ports: CLK/RST_N clock and async active-low reset; PACE_EN pacing enable;
//        HDR_* record-header handshake + timestamp; S_* raw packet stream in;
//        M_* paced packet stream out; PKT_COUNT packets released since reset.
module pcap_replay_pacer
    import pcap_replay_pacer_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = 250
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         PACE_EN,
    input  logic         HDR_VALID,
    output logic         HDR_READY,
    input  logic [31:0]  HDR_TS_SEC,
    input  logic [31:0]  HDR_TS_USEC,
    input  logic         S_TVALID,
    output logic         S_TREADY,
    input  logic [127:0] S_TDATA,
    input  logic [15:0]  S_TKEEP,
    input  logic         S_TLAST,
    output logic         M_TVALID,
    input  logic         M_TREADY,
    output logic [127:0] M_TDATA,
    output logic [15:0]  M_TKEEP,
    output logic         M_TLAST,
    output logic [31:0]  PKT_COUNT
);

    pacer_state_t r_state;
    pacer_state_t w_next;

    rec_hdr_ts_t  r_hdr;        // timestamp of the packet being paced
    rec_hdr_ts_t  r_ref;        // timestamp of the previously released packet
    logic         r_first;
    logic [31:0]  r_delta_us;
    logic [31:0]  r_pkt_count;

    logic [31:0]        w_elapsed_us;
    logic               w_timer_clr;
    logic               w_last_beat;
    logic signed [63:0] w_diff_sec;
    logic signed [63:0] w_diff_usec;
    logic signed [63:0] w_delta_raw;

    // Elapsed time runs from the start of one packet to the start of the next,
    // so it keeps counting through FWD and is only cleared on FWD entry.
    pcap_replay_pacer_usec_timer #(
        .CYCLES_PER_US (CYCLES_PER_US)
    ) u_usec_timer (
        .i_clk        (CLK),
        .i_rst_n      (RST_N),
        .i_clr        (w_timer_clr),
        .o_elapsed_us (w_elapsed_us)
    );

    // Both operands are zero-extended so the subtraction is a true signed difference.
    assign w_diff_sec  = $signed({32'd0, r_hdr.ts_sec})  - $signed({32'd0, r_ref.ts_sec});
    assign w_diff_usec = $signed({32'd0, r_hdr.ts_usec}) - $signed({32'd0, r_ref.ts_usec});
    assign w_delta_raw = w_diff_sec * $signed(64'(USEC_PER_SEC)) + w_diff_usec;

    // Sideband follows the input unconditionally; only valid/ready are gated.
    assign M_TDATA   = S_TDATA;
    assign M_TKEEP   = S_TKEEP;
    assign M_TLAST   = S_TLAST;
    assign PKT_COUNT = r_pkt_count;

    always_comb begin
        w_next      = r_state;
        HDR_READY   = 1'b0;
        M_TVALID    = 1'b0;
        S_TREADY    = 1'b0;
        w_timer_clr = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            ST_IDLE: begin
                HDR_READY = 1'b1;
                if (HDR_VALID) begin
                    w_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_next = ST_GAP;
            end
            ST_GAP: begin
                // A zero delta always satisfies the compare, giving a single GAP cycle.
                if ((w_elapsed_us >= r_delta_us) || !PACE_EN) begin
                    w_next      = ST_FWD;
                    w_timer_clr = 1'b1;
                end
            end
            ST_FWD: begin
                M_TVALID = S_TVALID;
                S_TREADY = M_TREADY;
                if (S_TVALID && M_TREADY && S_TLAST) begin
                    w_last_beat = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hdr       <= '0;
            r_ref       <= '0;
            r_first     <= 1'b1;
            r_delta_us  <= '0;
            r_pkt_count <= '0;
        end else begin
            if ((r_state == ST_IDLE) && HDR_VALID) begin
                r_hdr.ts_sec  <= HDR_TS_SEC;
                r_hdr.ts_usec <= HDR_TS_USEC;
            end
            if (r_state == ST_CALC) begin
                r_delta_us <= (r_first || !PACE_EN) ? 32'd0 : clamp_delta(w_delta_raw);
            end
            if (w_timer_clr) begin
                r_ref   <= r_hdr;
                r_first <= 1'b0;
            end
            if (w_last_beat) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcap_replay_pacer.sv
// Bench for pcap_replay_pacer at CYCLES_PER_US = 4: directed timing cases then randomized packets.
// Expected gaps come from a microsecond-arithmetic model of the capture timestamps; output beats
// are matched in order against the beats the bench generated.
module tb_pcap_replay_pacer;

    localparam int CPU    = 4;
    localparam int BUDGET = 3000;

    logic         CLK;
    logic         RST_N;
    logic         PACE_EN;
    logic         HDR_VALID;
    logic         HDR_READY;
    logic [31:0]  HDR_TS_SEC;
    logic [31:0]  HDR_TS_USEC;
    logic         S_TVALID;
    logic         S_TREADY;
    logic [127:0] S_TDATA;
    logic [15:0]  S_TKEEP;
    logic         S_TLAST;
    logic         M_TVALID;
    logic         M_TREADY;
    logic [127:0] M_TDATA;
    logic [15:0]  M_TKEEP;
    logic         M_TLAST;
    logic [31:0]  PKT_COUNT;

    pcap_replay_pacer #(.CYCLES_PER_US(CPU)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .PACE_EN     (PACE_EN),
        .HDR_VALID   (HDR_VALID),
        .HDR_READY   (HDR_READY),
        .HDR_TS_SEC  (HDR_TS_SEC),
        .HDR_TS_USEC (HDR_TS_USEC),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .S_TDATA     (S_TDATA),
        .S_TKEEP     (S_TKEEP),
        .S_TLAST     (S_TLAST),
        .M_TVALID    (M_TVALID),
        .M_TREADY    (M_TREADY),
        .M_TDATA     (M_TDATA),
        .M_TKEEP     (M_TKEEP),
        .M_TLAST     (M_TLAST),
        .PKT_COUNT   (PKT_COUNT)
    );

    typedef struct {
        logic [127:0] dat;
        logic [15:0]  keep;
        logic         last;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bp_mode = 0;        // 0: always ready, 1: toggle each cycle, 2: random
    beat_t exp_q[$];

    // monitor state
    int mon_start = 0;
    int mon_beats = 0;
    bit in_pkt    = 0;
    bit prev_hold = 0;

    // reference model state
    logic [31:0] mref_sec;
    logic [31:0] mref_usec;
    bit          mfirst;
    logic [31:0] mcount;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Gap in microseconds implied by two capture timestamps.
    function automatic longint model_delta(input logic [31:0] s, input logic [31:0] u,
                                           input logic [31:0] rs, input logic [31:0] ru,
                                           input bit first, input bit pace);
        longint d;
        if (first || !pace) return 0;
        d = (longint'({32'h0, s}) - longint'({32'h0, rs})) * 1000000
          + (longint'({32'h0, u}) - longint'({32'h0, ru}));
        if (d < 0) return 0;
        if (d > 64'sd4294967295) return 64'sd4294967295;
        return d;
    endfunction

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    initial begin
        M_TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (bp_mode)
                1:       M_TREADY = ~M_TREADY;
                2:       M_TREADY = 1'($urandom_range(0, 1));
                default: M_TREADY = 1'b1;
            endcase
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Output monitor: in-order beat check, stall stability, quiet outputs while idle.
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                in_pkt    = 0;
                prev_hold = 0;
            end else begin
                if (prev_hold) check("vld_hold", M_TVALID, 1);
                if (HDR_READY) begin
                    check("idle_m_tvalid", M_TVALID, 0);
                    check("idle_s_tready", S_TREADY, 0);
                end
                if (M_TVALID && !in_pkt) begin
                    in_pkt    = 1;
                    mon_start = cyc;
                end
                if (M_TVALID && M_TREADY) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tdata", M_TDATA, e.dat);
                        check("tkeep", M_TKEEP, e.keep);
                        check("tlast", M_TLAST, e.last);
                    end
                    mon_beats++;
                    if (M_TLAST) in_pkt = 0;
                end
                prev_hold = M_TVALID && !M_TREADY;
            end
        end
    end

    task automatic do_reset();
        S_TVALID  = 1'b0;
        HDR_VALID = 1'b0;
        RST_N     = 1'b0;
        @(negedge CLK);
        check("rst_m_tvalid", M_TVALID, 0);
        check("rst_s_tready", S_TREADY, 0);
        check("rst_pkt_count", PKT_COUNT, 0);
        exp_q.delete();
        mref_sec  = 0;
        mref_usec = 0;
        mfirst    = 1;
        mcount    = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_hdr_ready", HDR_READY, 1);
        @(posedge CLK);
        #1;
    endtask

    // One record: header handshake, then nb beats. drop_at >= 0 clears PACE_EN that many
    // cycles after the header; rst_after > 0 resets after that many accepted input beats.
    task automatic send_pkt(input logic [31:0] sec, input logic [31:0] usec, input int nb,
                            input bit pace, input int drop_at, input int rst_after);
        longint d;
        longint lo;
        longint hi;
        int prev_start;
        int hs_cyc;
        int drop_cyc;
        int out0;
        int sent;
        int since;
        bit ok;
        beat_t b;

        prev_start = mon_start;
        d = model_delta(sec, usec, mref_sec, mref_usec, mfirst, pace);
        mref_sec  = sec;
        mref_usec = usec;
        mfirst    = 0;

        PACE_EN     = pace;
        HDR_TS_SEC  = sec;
        HDR_TS_USEC = usec;
        HDR_VALID   = 1'b1;
        ok = 0;
        hs_cyc = 0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge CLK);
            if (HDR_READY) begin
                ok = 1;
                hs_cyc = cyc;
            end
            @(posedge CLK);
            #1;
            if (ok) break;
        end
        HDR_VALID = 1'b0;
        check("hdr_accept", ok, 1);
        if (!ok) return;

        out0 = mon_beats;
        sent = 0;
        since = 0;
        drop_cyc = -1;
        for (int k = 0; k < nb; k++) begin
            b.dat  = {$urandom, $urandom, $urandom, $urandom};
            b.keep = (k == nb - 1) ? 16'($urandom_range(1, 65535)) : 16'hFFFF;
            b.last = (k == nb - 1);
            exp_q.push_back(b);
            S_TDATA  = b.dat;
            S_TKEEP  = b.keep;
            S_TLAST  = b.last;
            S_TVALID = 1'b1;
            ok = 0;
            for (int i = 0; i < BUDGET; i++) begin
                if (since == drop_at) begin
                    PACE_EN  = 1'b0;
                    drop_cyc = cyc;
                end
                since++;
                @(negedge CLK);
                if (S_TREADY) ok = 1;
                @(posedge CLK);
                #1;
                if (ok) break;
            end
            check("beat_accept", ok, 1);
            if (!ok) break;
            sent++;
            if (sent == rst_after) begin
                check("pre_rst_beats", mon_beats - out0, sent);
                do_reset();
                return;
            end
        end
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;

        mcount = mcount + 32'd1;
        check("pkt_count", PKT_COUNT, mcount);
        check("out_beats", mon_beats - out0, nb);

        if (drop_cyc >= 0) begin
            check("drop_to_fwd", mon_start, drop_cyc + 1);
        end else begin
            lo = longint'(prev_start) + longint'(CPU) * d;
            hi = lo + CPU;
            if (lo < hs_cyc + 3) lo = hs_cyc + 3;
            if (hi < hs_cyc + 3) hi = hs_cyc + 3;
            if (lo == hi) begin
                check("start_exact", mon_start, lo);
            end else begin
                check("start_window", (mon_start >= lo) && (mon_start <= hi), 1);
                if (!((mon_start >= lo) && (mon_start <= hi)))
                    $display("  start=%0d window=[%0d,%0d] delta_us=%0d", mon_start, lo, hi, d);
            end
        end
    endtask

    initial begin
        longint tot;
        longint off;
        PACE_EN     = 1'b1;
        HDR_VALID   = 1'b0;
        HDR_TS_SEC  = '0;
        HDR_TS_USEC = '0;
        S_TVALID    = 1'b0;
        S_TDATA     = '0;
        S_TKEEP     = '0;
        S_TLAST     = 1'b0;
        RST_N       = 1'b1;
        @(posedge CLK);
        #1;
        do_reset();

        send_pkt(32'd10, 32'd500,    3, 1, -1, 0);  // first packet: zero gap
        send_pkt(32'd10, 32'd520,    3, 1, -1, 0);  // 20 us -> 80..84 cycles start-to-start
        send_pkt(32'd10, 32'd999990, 2, 0, -1, 0);  // unpaced, sets reference
        send_pkt(32'd11, 32'd0,      2, 1, -1, 0);  // 10 us across a second boundary
        send_pkt(32'd9,  32'd0,      2, 1, -1, 0);  // backwards -> zero gap
        send_pkt(32'd10, 32'd0,      2, 0, -1, 0);  // unpaced 1 s apart
        send_pkt(32'd11, 32'd0,      2, 0, -1, 0);
        send_pkt(32'd12, 32'd0,      3, 1,  5, 0);  // 1 s gap cut short by PACE_EN drop
        bp_mode = 1;
        send_pkt(32'd12, 32'd5,      8, 1, -1, 3);  // toggled ready, reset mid-packet
        bp_mode = 0;
        send_pkt(32'd100, 32'd999980, 2, 1, -1, 0); // first after reset: zero gap

        tot = 64'd100_999_980;
        for (int n = 0; n < 30; n++) begin
            off = longint'($urandom_range(0, 80)) - 50;
            tot = tot + off;
            bp_mode = int'($urandom_range(0, 2));
            send_pkt(32'(tot / 1000000), 32'(tot % 1000000), int'($urandom_range(1, 4)),
                     ($urandom_range(0, 3) != 0), -1, 0);
        end
        bp_mode = 0;
        repeat (4) @(posedge CLK);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
